id_exe_reg: RTL and testbench
=============================

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001: Parameters SHALL be: DATA_W, 32, operand/PC/immediate width; REG_W, 5, register-index width; CNT_W, 16, bubble-counter width.
REQ-002: clk  in  1  rising-edge clock for all state.
REQ-003: rst_n  in  1  reset, asynchronous and active-low; one clock for the whole block.
REQ-004: id_valid  in  1  ID stage holds a real instruction.
REQ-005: hold_exe  in  1  global pipeline freeze (memory wait); register keeps contents.
REQ-006: flush_exe_reg  in  1  load-use bubble request from hazard control.
REQ-007: id_pc  in  DATA_W  PC of ID instruction.
REQ-008: id_instr_opcode  in  7  ID opcode.
REQ-009: id_rd  in  REG_W  destination index; id_has_rd  in  1  writes rd; id_is_store  in  1  store.
REQ-010: id_rs1_data, id_rs2_data  in  DATA_W  register-file read data.
REQ-011: id_imm  in  DATA_W  decoded immediate.
REQ-012: forwarding_a_option, forwarding_b_option  in  2  operand source select from hazard control.
REQ-013: exe_result, mem_result, wb_result  in  DATA_W  forwarding sources from EXE, MEM, WB.
REQ-014: ex_pc, ex_op_a, ex_op_b, ex_imm  out  DATA_W  registered EXE-stage values.
REQ-015: ex_instr_opcode  out  7; ex_rd  out  REG_W; ex_has_rd, ex_is_store  out  1  registered control.
REQ-016: ex_valid  out  1  EXE holds a real instruction; ex_is_flushed  out  1  EXE holds an inserted bubble.
REQ-017: bubble_count  out  CNT_W  saturating count of load-use bubbles inserted.

Function
REQ-018: Operand A select SHALL be combinational: 00 id_rs1_data, 01 exe_result, 10 mem_result, 11 wb_result; operand B identical using forwarding_b_option and id_rs2_data.
REQ-019: Per rising clk edge, priority SHALL be: hold_exe, then flush_exe_reg, then capture.
REQ-020: hold_exe=1 SHALL keep every output register, including bubble_count, unchanged regardless of other inputs.
REQ-021: hold_exe=0, flush_exe_reg=1 SHALL load a bubble: opcode 7'b0010011, rd 0, has_rd 0, is_store 0, pc/op_a/op_b/imm 0, ex_valid 0, ex_is_flushed 1.
REQ-022: Bubble opcode SHALL never be 7'b0000011, so a bubble never re-triggers a load-use stall.
REQ-023: hold_exe=0, flush_exe_reg=0, id_valid=1 SHALL capture selected operands and all id_* fields; ex_valid 1, ex_is_flushed 0.
REQ-024: hold_exe=0, flush_exe_reg=0, id_valid=0 SHALL load the bubble of REQ-021 except ex_is_flushed 0.
REQ-025: Latency SHALL be exactly one cycle from ID inputs to ex_* outputs; no combinational path from inputs to outputs.
REQ-026: bubble_count SHALL increment by 1 only on an edge where REQ-021 applies; held at all-ones when saturated.
REQ-027: Forwarded operand SHALL be the value present at the capturing edge, sampled the same cycle as forwarding option.
REQ-028: A store captures forwarded rs2 into ex_op_b as store data; no separate store-data path.

Reset
REQ-029: rst_n low SHALL immediately, asynchronously, force the REQ-021 bubble values with ex_is_flushed 0, ex_valid 0, and bubble_count 0.
REQ-030: Reset mid-operation SHALL discard the held instruction; first edge after rst_n rises follows REQ-019 normally.
REQ-031: Reset dominates hold_exe and flush_exe_reg.

Verification
REQ-032: Capture: id_valid=1, id_pc=0x100, opcode 0x33, rd 5, options 00, rs1_data=7, rs2_data=9 -> next cycle ex_pc=0x100, ex_op_a=7, ex_op_b=9, ex_rd=5, ex_valid=1.
REQ-033: Forwarding: forwarding_a_option=01 exe_result=0xAA, forwarding_b_option=11 wb_result=0x55 -> ex_op_a=0xAA, ex_op_b=0x55.
REQ-034: Load-use: flush_exe_reg=1 for 1 cycle -> ex_opcode=0x13, ex_has_rd=0, ex_is_flushed=1, ex_valid=0, bubble_count 0->1.
REQ-035: Freeze: hold_exe=1 with flush_exe_reg=1 for 3 cycles -> outputs and bubble_count unchanged all 3 cycles.
REQ-036: Saturation: preload 0xFFFE bubbles, two more flushes -> bubble_count 0xFFFF, stays 0xFFFF.
REQ-037: Async reset: rst_n low between edges with valid instruction held -> outputs bubble and bubble_count 0 before next clk edge.

Source files
------------

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: selects forwarded operands, then registers the
// decoded instruction (or a NOP bubble) for the EXE stage, with a bubble counter.
module id_exe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              hold_exe,
  input  logic              flush_exe_reg,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [6:0]        id_instr_opcode,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_has_rd,
  input  logic              id_is_store,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        forwarding_a_option,
  input  logic [1:0]        forwarding_b_option,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [6:0]        ex_instr_opcode,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_has_rd,
  output logic              ex_is_store,
  output logic              ex_valid,
  output logic              ex_is_flushed,
  output logic [CNT_W-1:0]  bubble_count
);

  // ADDI x0,x0,0: a NOP that is never a load, so it cannot re-trigger a load-use stall
  localparam logic [6:0] BUBBLE_OP = 7'b0010011;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic [6:0]        opcode;
    logic [REG_W-1:0]  rd;
    logic              has_rd;
    logic              is_store;
    logic              valid;
    logic              flushed;
  } exe_t;

  localparam exe_t BUBBLE = '{
    pc: '0, op_a: '0, op_b: '0, imm: '0, opcode: BUBBLE_OP,
    rd: '0, has_rd: 1'b0, is_store: 1'b0, valid: 1'b0, flushed: 1'b0
  };

  logic [DATA_W-1:0] fwd_a, fwd_b;
  exe_t              ex_q, ex_d;
  logic              bubble_ins;

  always_comb begin
    fwd_a = id_rs1_data;
    case (forwarding_a_option)
      2'b01:   fwd_a = exe_result;
      2'b10:   fwd_a = mem_result;
      2'b11:   fwd_a = wb_result;
      default: fwd_a = id_rs1_data;
    endcase
    fwd_b = id_rs2_data;
    case (forwarding_b_option)
      2'b01:   fwd_b = exe_result;
      2'b10:   fwd_b = mem_result;
      2'b11:   fwd_b = wb_result;
      default: fwd_b = id_rs2_data;
    endcase
  end

  assign bubble_ins = !hold_exe && flush_exe_reg;

  // Store data rides in op_b; there is no separate store-data path.
  always_comb begin
    ex_d = ex_q;
    if (!hold_exe) begin
      if (flush_exe_reg) begin
        ex_d         = BUBBLE;
        ex_d.flushed = 1'b1;
      end else if (id_valid) begin
        ex_d.pc       = id_pc;
        ex_d.op_a     = fwd_a;
        ex_d.op_b     = fwd_b;
        ex_d.imm      = id_imm;
        ex_d.opcode   = id_instr_opcode;
        ex_d.rd       = id_rd;
        ex_d.has_rd   = id_has_rd;
        ex_d.is_store = id_is_store;
        ex_d.valid    = 1'b1;
        ex_d.flushed  = 1'b0;
      end else begin
        ex_d = BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= BUBBLE;
      bubble_count <= '0;
    end else begin
      ex_q <= ex_d;
      if (bubble_ins && (bubble_count != {CNT_W{1'b1}}))
        bubble_count <= bubble_count + 1'b1;
    end
  end

  assign ex_pc           = ex_q.pc;
  assign ex_op_a         = ex_q.op_a;
  assign ex_op_b         = ex_q.op_b;
  assign ex_imm          = ex_q.imm;
  assign ex_instr_opcode = ex_q.opcode;
  assign ex_rd           = ex_q.rd;
  assign ex_has_rd       = ex_q.has_rd;
  assign ex_is_store     = ex_q.is_store;
  assign ex_valid        = ex_q.valid;
  assign ex_is_flushed   = ex_q.flushed;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: capture, forwarding, bubbles, freeze,
// counter saturation and asynchronous reset, checked with immediate assertions.
module tb_id_exe_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              id_valid, hold_exe, flush_exe_reg;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [6:0]        id_instr_opcode;
  logic [REG_W-1:0]  id_rd;
  logic              id_has_rd, id_is_store;
  logic [1:0]        forwarding_a_option, forwarding_b_option;
  logic [DATA_W-1:0] exe_result, mem_result, wb_result;
  logic [DATA_W-1:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [6:0]        ex_instr_opcode;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_has_rd, ex_is_store, ex_valid, ex_is_flushed;
  logic [CNT_W-1:0]  bubble_count;

  int total = 0;
  int bad   = 0;

  id_exe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .hold_exe(hold_exe),
    .flush_exe_reg(flush_exe_reg), .id_pc(id_pc), .id_instr_opcode(id_instr_opcode),
    .id_rd(id_rd), .id_has_rd(id_has_rd), .id_is_store(id_is_store),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .forwarding_a_option(forwarding_a_option), .forwarding_b_option(forwarding_b_option),
    .exe_result(exe_result), .mem_result(mem_result), .wb_result(wb_result),
    .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .ex_instr_opcode(ex_instr_opcode), .ex_rd(ex_rd), .ex_has_rd(ex_has_rd),
    .ex_is_store(ex_is_store), .ex_valid(ex_valid), .ex_is_flushed(ex_is_flushed),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag, input logic flushed);
    chk({tag, ".opcode"}, 64'(ex_instr_opcode), 64'h13);
    chk({tag, ".has_rd"}, 64'(ex_has_rd), 64'h0);
    chk({tag, ".rd"}, 64'(ex_rd), 64'h0);
    chk({tag, ".store"}, 64'(ex_is_store), 64'h0);
    chk({tag, ".pc"}, 64'(ex_pc), 64'h0);
    chk({tag, ".op_a"}, 64'(ex_op_a), 64'h0);
    chk({tag, ".op_b"}, 64'(ex_op_b), 64'h0);
    chk({tag, ".imm"}, 64'(ex_imm), 64'h0);
    chk({tag, ".valid"}, 64'(ex_valid), 64'h0);
    chk({tag, ".flushed"}, 64'(ex_is_flushed), 64'(flushed));
  endtask

  initial begin
    id_valid = 1'b0; hold_exe = 1'b0; flush_exe_reg = 1'b0;
    id_pc = '0; id_instr_opcode = '0; id_rd = '0; id_has_rd = 1'b0; id_is_store = 1'b0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    forwarding_a_option = 2'b00; forwarding_b_option = 2'b00;
    exe_result = 32'hAA; mem_result = 32'h77; wb_result = 32'h55;

    // reset state, asserted before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk_bubble("reset", 1'b0);
    chk("reset.count", 64'(bubble_count), 64'h0);

    // capture with register-file operands
    id_valid = 1'b1; id_pc = 32'h100; id_instr_opcode = 7'h33; id_rd = 5'd5;
    id_has_rd = 1'b1; id_rs1_data = 32'd7; id_rs2_data = 32'd9; id_imm = 32'h1234;
    #1 rst_n = 1'b1;
    step();
    chk("cap.pc", 64'(ex_pc), 64'h100);
    chk("cap.op_a", 64'(ex_op_a), 64'd7);
    chk("cap.op_b", 64'(ex_op_b), 64'd9);
    chk("cap.rd", 64'(ex_rd), 64'd5);
    chk("cap.has_rd", 64'(ex_has_rd), 64'h1);
    chk("cap.opcode", 64'(ex_instr_opcode), 64'h33);
    chk("cap.imm", 64'(ex_imm), 64'h1234);
    chk("cap.valid", 64'(ex_valid), 64'h1);
    chk("cap.flushed", 64'(ex_is_flushed), 64'h0);

    // forwarding A from EXE, B from WB; outputs must not move before the edge
    id_pc = 32'h104; forwarding_a_option = 2'b01; forwarding_b_option = 2'b11;
    #2;
    chk("nocomb.pc", 64'(ex_pc), 64'h100);
    chk("nocomb.op_a", 64'(ex_op_a), 64'd7);
    step();
    chk("fwd.op_a", 64'(ex_op_a), 64'hAA);
    chk("fwd.op_b", 64'(ex_op_b), 64'h55);
    chk("fwd.pc", 64'(ex_pc), 64'h104);

    // store: A from MEM, B (store data) from EXE
    id_pc = 32'h108; id_instr_opcode = 7'h23; id_is_store = 1'b1; id_has_rd = 1'b0;
    forwarding_a_option = 2'b10; forwarding_b_option = 2'b01; exe_result = 32'hDEAD_BEEF;
    step();
    chk("st.op_a", 64'(ex_op_a), 64'h77);
    chk("st.op_b", 64'(ex_op_b), 64'hDEAD_BEEF);
    chk("st.is_store", 64'(ex_is_store), 64'h1);
    chk("st.has_rd", 64'(ex_has_rd), 64'h0);

    // id_valid low: bubble without flush flag, counter unchanged
    id_valid = 1'b0;
    step();
    chk_bubble("idle", 1'b0);
    chk("idle.count", 64'(bubble_count), 64'h0);

    // load-use bubble for one cycle
    id_valid = 1'b1; flush_exe_reg = 1'b1;
    step();
    chk_bubble("flush", 1'b1);
    chk("flush.count", 64'(bubble_count), 64'h1);

    // capture a real instruction, then freeze with flush asserted for 3 cycles
    flush_exe_reg = 1'b0; id_pc = 32'h200; id_instr_opcode = 7'h03; id_rd = 5'd3;
    id_has_rd = 1'b1; id_is_store = 1'b0; forwarding_a_option = 2'b00; id_rs1_data = 32'h11;
    step();
    chk("pre_hold.pc", 64'(ex_pc), 64'h200);
    hold_exe = 1'b1; flush_exe_reg = 1'b1; id_pc = 32'h300; id_rs1_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.pc", 64'(ex_pc), 64'h200);
      chk("hold.op_a", 64'(ex_op_a), 64'h11);
      chk("hold.opcode", 64'(ex_instr_opcode), 64'h03);
      chk("hold.valid", 64'(ex_valid), 64'h1);
      chk("hold.flushed", 64'(ex_is_flushed), 64'h0);
      chk("hold.count", 64'(bubble_count), 64'h1);
    end

    // saturation: from 1, 0xFFFD more flushes reach 0xFFFE
    hold_exe = 1'b0;
    repeat (16'hFFFD) @(posedge clk);
    #1;
    chk("sat.preload", 64'(bubble_count), 64'hFFFE);
    step();
    chk("sat.max", 64'(bubble_count), 64'hFFFF);
    step();
    chk("sat.hold", 64'(bubble_count), 64'hFFFF);

    // asynchronous reset between edges with a valid instruction held
    flush_exe_reg = 1'b0; id_valid = 1'b1; id_pc = 32'h400;
    step();
    chk("prerst.valid", 64'(ex_valid), 64'h1);
    hold_exe = 1'b1; flush_exe_reg = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_bubble("arst", 1'b0);
    chk("arst.count", 64'(bubble_count), 64'h0);
    step();
    chk("arst.dom.valid", 64'(ex_valid), 64'h0);
    chk("arst.dom.count", 64'(bubble_count), 64'h0);

    // first edge after release behaves normally
    hold_exe = 1'b0; flush_exe_reg = 1'b0; id_pc = 32'h500;
    rst_n = 1'b1;
    step();
    chk("post.pc", 64'(ex_pc), 64'h500);
    chk("post.valid", 64'(ex_valid), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
